// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor update path.
package bp_pkg;

  localparam int BP_PHT_AW = 7;
  localparam int BP_BHT_AW = 4;

  // 2-bit saturating counter encodings
  localparam logic [1:0] STRONG_T  = 2'b11;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] STRONG_NT = 2'b00;

  // Values the predictor writes when upd_init is set
  localparam logic [1:0]           PHT_INIT = STRONG_T;
  localparam logic [BP_BHT_AW-1:0] BHT_INIT = '0;

  typedef struct packed {
    logic [BP_PHT_AW-1:0] pht_index;
    logic [BP_BHT_AW-1:0] bht_index;
    logic                 taken;
  } bp_upd_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-write / one-read synchronous FIFO of predictor updates.
// Slot 0 lands before slot 1; the count is the only full/empty authority.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr0_en,
  input  bp_upd_t                  wr0_data,
  input  logic                     wr1_en,
  input  bp_upd_t                  wr1_data,
  input  logic                     rd_en,
  output bp_upd_t                  rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bp_upd_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [1:0]     n_wr;

  assign n_wr    = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign rd_data = mem[rd_ptr];

  // Storage; a lone slot-1 write takes the slot-0 position
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (wr0_en) mem[wr_ptr] <= wr0_data;
      if (wr1_en) mem[wr0_en ? wr_ptr + PW'(1) : wr_ptr] <= wr1_data;
    end
  end

  // Pointers wrap at DEPTH; count tracks pushes minus pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_wr);
      rd_ptr <= rd_ptr + PW'(rd_en);
      count  <= count + CW'(n_wr) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/bp_update_sequencer.sv
// Single write-port sequencer for the BHT/PHT predictor tables.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   INIT  | sweep every PHT entry (and BHT via low bits) to init value
//   RUN   | drain retired-branch updates from the FIFO, one per cycle
module bp_update_sequencer
  import bp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PHT_AW = BP_PHT_AW,
  parameter int BHT_AW = BP_BHT_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init_req,
  input  logic                     ret0_valid,
  input  logic [PHT_AW-1:0]        ret0_pht_index,
  input  logic [BHT_AW-1:0]        ret0_bht_index,
  input  logic                     ret0_taken,
  input  logic                     ret1_valid,
  input  logic [PHT_AW-1:0]        ret1_pht_index,
  input  logic [BHT_AW-1:0]        ret1_bht_index,
  input  logic                     ret1_taken,
  output logic                     ret_ready,
  output logic                     upd_en,
  output logic                     upd_init,
  output logic [PHT_AW-1:0]        upd_pht_index,
  output logic [BHT_AW-1:0]        upd_bht_index,
  output logic                     upd_taken,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  bp_state_t          state_q, state_d;
  logic [PHT_AW-1:0]  cnt_q, cnt_d;
  logic               busy_q;

  logic               upd_en_d, upd_init_d, upd_taken_d;
  logic [PHT_AW-1:0]  upd_pht_d;
  logic [BHT_AW-1:0]  upd_bht_d;

  bp_upd_t            wr0_data, wr1_data, head;
  logic               push0, push1, pop;
  logic [CW-1:0]      free_slots;

  // busy_q stays high through the cycle that shows the last sweep write,
  // so ready only rises once the predictor has seen the whole sweep.
  assign free_slots = CW'(DEPTH) - fifo_count;
  assign ret_ready  = !busy_q && (free_slots >= CW'(2));
  assign busy       = busy_q;

  // A valid slot offered while not ready is dropped (protocol violation)
  assign push0 = ret_ready && ret0_valid;
  assign push1 = ret_ready && ret1_valid;
  assign pop   = (state_q == RUN) && (fifo_count != '0) && !init_req;

  assign wr0_data = '{pht_index: ret0_pht_index, bht_index: ret0_bht_index, taken: ret0_taken};
  assign wr1_data = '{pht_index: ret1_pht_index, bht_index: ret1_bht_index, taken: ret1_taken};

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (init_req),
    .wr0_en   (push0),
    .wr0_data (wr0_data),
    .wr1_en   (push1),
    .wr1_data (wr1_data),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (fifo_count)
  );

  // Next state, sweep counter and next update-port values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    upd_en_d    = 1'b0;
    upd_init_d  = 1'b0;
    upd_pht_d   = '0;
    upd_bht_d   = '0;
    upd_taken_d = 1'b0;
    if (init_req) begin
      // Restart wins over everything; queued updates are abandoned
      state_d = INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        INIT: begin
          upd_en_d   = 1'b1;
          upd_init_d = 1'b1;
          upd_pht_d  = cnt_q;
          upd_bht_d  = cnt_q[BHT_AW-1:0];
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = RUN;
        end
        RUN: begin
          if (pop) begin
            upd_en_d    = 1'b1;
            upd_pht_d   = head.pht_index;
            upd_bht_d   = head.bht_index;
            upd_taken_d = head.taken;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  // State, counter and registered update-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      busy_q        <= 1'b1;
      upd_en        <= 1'b0;
      upd_init      <= 1'b0;
      upd_pht_index <= '0;
      upd_bht_index <= '0;
      upd_taken     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= init_req || (state_q == INIT);
      upd_en        <= upd_en_d;
      upd_init      <= upd_init_d;
      upd_pht_index <= upd_pht_d;
      upd_bht_index <= upd_bht_d;
      upd_taken     <= upd_taken_d;
    end
  end

  // The retire stage must never present a branch while ready is low
  a_no_drop: assert property (@(posedge clk) disable iff (reset)
    (ret0_valid || ret1_valid) |-> ret_ready);

endmodule

// File: tb/tb_bp_update_sequencer.sv
// Randomized, self-checking bench for bp_update_sequencer.
module tb_bp_update_sequencer;

  localparam int DEPTH  = 4;
  localparam int PHT_AW = 7;
  localparam int BHT_AW = 4;
  localparam int NPHT   = 1 << PHT_AW;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_req;
  logic              ret0_valid, ret0_taken, ret1_valid, ret1_taken;
  logic [PHT_AW-1:0] ret0_pht_index, ret1_pht_index;
  logic [BHT_AW-1:0] ret0_bht_index, ret1_bht_index;
  logic              ret_ready, upd_en, upd_init, upd_taken, busy;
  logic [PHT_AW-1:0] upd_pht_index;
  logic [BHT_AW-1:0] upd_bht_index;
  logic [2:0]        fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pht;
    int bht;
    bit taken;
  } upd_m_t;

  // Reference model: updates accepted but not yet seen on the port
  upd_m_t fifo_m[$];
  int     max_cnt;
  bit     saw_not_ready;

  bp_update_sequencer #(.DEPTH(DEPTH), .PHT_AW(PHT_AW), .BHT_AW(BHT_AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .init_req       (init_req),
    .ret0_valid     (ret0_valid),
    .ret0_pht_index (ret0_pht_index),
    .ret0_bht_index (ret0_bht_index),
    .ret0_taken     (ret0_taken),
    .ret1_valid     (ret1_valid),
    .ret1_pht_index (ret1_pht_index),
    .ret1_bht_index (ret1_bht_index),
    .ret1_taken     (ret1_taken),
    .ret_ready      (ret_ready),
    .upd_en         (upd_en),
    .upd_init       (upd_init),
    .upd_pht_index  (upd_pht_index),
    .upd_bht_index  (upd_bht_index),
    .upd_taken      (upd_taken),
    .busy           (busy),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_req = 0;
    ret0_valid = 0; ret0_pht_index = '0; ret0_bht_index = '0; ret0_taken = 0;
    ret1_valid = 0; ret1_pht_index = '0; ret1_bht_index = '0; ret1_taken = 0;
  endtask

  task automatic test_reset();
    logic [15:0] obs, exp;
    int writes;
    idle_inputs();
    reset = 1;
    #2;
    checks++;
    if ({upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready, fifo_count}
        !== {1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_values: en=%b init=%b pht=%0d bht=%0d tk=%b busy=%b rdy=%b cnt=%0d, want all 0 except busy=1",
               upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready, fifo_count);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    fifo_m.delete();
    writes = 0;
    for (int k = 1; k <= NPHT + 2; k++) begin
      tick();
      obs = {upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready};
      if (k <= NPHT) exp = {1'b1, 1'b1, 7'(k - 1), 4'((k - 1) % 16), 1'b0, 1'b1, 1'b0};
      else           exp = {1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1};
      if (upd_en && upd_init) writes++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sweep_cycle_%0d: got %h, want %h", k, obs, exp);
      end
    end
    checks++;
    if (writes != NPHT) begin
      errors++;
      $display("FAIL sweep_length: got %0d writes, want %0d", writes, NPHT);
    end
  endtask

  task automatic test_single();
    ret0_valid = 1; ret0_pht_index = 7'd5; ret0_bht_index = 4'd3; ret0_taken = 1;
    tick();
    ret0_valid = 0;
    checks++;
    if ({upd_en, fifo_count} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL single_enqueue: en=%b cnt=%0d, want en=0 cnt=1", upd_en, fifo_count);
    end
    tick();
    checks++;
    if ({upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, fifo_count}
        !== {1'b1, 1'b0, 7'd5, 4'd3, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL single_update: en=%b init=%b pht=%0d bht=%0d tk=%b cnt=%0d, want 1 0 5 3 1 0",
               upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, fifo_count);
    end
    tick();
    checks++;
    if (upd_en !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: en=%b, want 0", upd_en);
    end
  endtask

  task automatic test_pair();
    ret0_valid = 1; ret0_pht_index = 7'd10; ret0_bht_index = 4'd1; ret0_taken = 1;
    ret1_valid = 1; ret1_pht_index = 7'd11; ret1_bht_index = 4'd2; ret1_taken = 0;
    tick();
    ret0_valid = 0; ret1_valid = 0;
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pair_count: got %0d, want 2", fifo_count);
    end
    tick();
    checks++;
    if ({upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken} !== {1'b1, 1'b0, 7'd10, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL pair_first: en=%b init=%b pht=%0d bht=%0d tk=%b, want 1 0 10 1 1",
               upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken);
    end
    tick();
    checks++;
    if ({upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, fifo_count}
        !== {1'b1, 1'b0, 7'd11, 4'd2, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL pair_second: en=%b init=%b pht=%0d bht=%0d tk=%b cnt=%0d, want 1 0 11 2 0 0",
               upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, fifo_count);
    end
  endtask

  // Random retire traffic scored against a queue model of the FIFO
  task automatic run_traffic(input int n, input int pct, input bit both);
    upd_m_t e, d0, d1;
    bit had, exp_ready, v0, v1;
    for (int c = 0; c < n; c++) begin
      exp_ready = (DEPTH - fifo_m.size()) >= 2;
      checks++;
      if (ret_ready !== exp_ready) begin
        errors++;
        $display("FAIL ready_c%0d: got %b, want %b (model occupancy %0d)", c, ret_ready, exp_ready, fifo_m.size());
      end
      if (!ret_ready) saw_not_ready = 1;
      v0 = 0; v1 = 0;
      if (ret_ready === 1'b1) begin
        v0 = ($urandom_range(0, 99) < pct);
        v1 = both ? v0 : ($urandom_range(0, 99) < pct);
      end
      d0.pht = $urandom_range(0, NPHT - 1); d0.bht = $urandom_range(0, 15); d0.taken = 1'($urandom);
      d1.pht = $urandom_range(0, NPHT - 1); d1.bht = $urandom_range(0, 15); d1.taken = 1'($urandom);
      ret0_valid = v0; ret0_pht_index = 7'(d0.pht); ret0_bht_index = 4'(d0.bht); ret0_taken = d0.taken;
      ret1_valid = v1; ret1_pht_index = 7'(d1.pht); ret1_bht_index = 4'(d1.bht); ret1_taken = d1.taken;
      had = fifo_m.size() > 0;
      if (had) e = fifo_m.pop_front();
      if (v0) fifo_m.push_back(d0);
      if (v1) fifo_m.push_back(d1);
      tick();
      ret0_valid = 0; ret1_valid = 0;
      if (fifo_m.size() > max_cnt) max_cnt = fifo_m.size();
      checks++;
      if (had) begin
        if ({upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken}
            !== {1'b1, 1'b0, 7'(e.pht), 4'(e.bht), e.taken}) begin
          errors++;
          $display("FAIL update_c%0d: en=%b init=%b pht=%0d bht=%0d tk=%b, want 1 0 %0d %0d %0d",
                   c, upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, e.pht, e.bht, e.taken);
        end
      end else if (upd_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_c%0d: en=%b, want 0", c, upd_en);
      end
      checks++;
      if (fifo_count !== 3'(fifo_m.size())) begin
        errors++;
        $display("FAIL count_c%0d: got %0d, want %0d", c, fifo_count, fifo_m.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    max_cnt = 0;
    saw_not_ready = 0;
    run_traffic(6, 100, 1);
    checks++;
    if (max_cnt != 3 || !saw_not_ready) begin
      errors++;
      $display("FAIL b2b_fill: peak occupancy %0d ready_low_seen %0d, want 3 and 1", max_cnt, saw_not_ready);
    end
    run_traffic(5, 0, 0);
    checks++;
    if (fifo_count !== 3'd0 || fifo_m.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: dut %0d model %0d, want 0", fifo_count, fifo_m.size());
    end
  endtask

  task automatic test_init_req();
    logic [15:0] obs, exp;
    ret0_valid = 1; ret0_pht_index = 7'd20; ret0_bht_index = 4'd4; ret0_taken = 1;
    ret1_valid = 1; ret1_pht_index = 7'd21; ret1_bht_index = 4'd5; ret1_taken = 0;
    tick();
    ret0_pht_index = 7'd22; ret1_pht_index = 7'd23;
    tick();
    ret0_valid = 0; ret1_valid = 0;
    checks++;
    if ({fifo_count, ret_ready, upd_en, upd_pht_index} !== {3'd3, 1'b0, 1'b1, 7'd20}) begin
      errors++;
      $display("FAIL initreq_setup: cnt=%0d rdy=%b en=%b pht=%0d, want 3 0 1 20",
               fifo_count, ret_ready, upd_en, upd_pht_index);
    end
    init_req = 1;
    tick();
    init_req = 0;
    fifo_m.delete();
    checks++;
    if ({upd_en, fifo_count, busy, ret_ready} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL initreq_flush: en=%b cnt=%0d busy=%b rdy=%b, want 0 0 1 0",
               upd_en, fifo_count, busy, ret_ready);
    end
    for (int k = 1; k <= NPHT + 1; k++) begin
      tick();
      obs = {upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready};
      if (k <= NPHT) exp = {1'b1, 1'b1, 7'(k - 1), 4'((k - 1) % 16), 1'b0, 1'b1, 1'b0};
      else           exp = {1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL resweep_cycle_%0d: got %h, want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs, exp;
    int guard;
    init_req = 1;
    tick();
    init_req = 0;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(upd_en && upd_init && upd_pht_index == 7'd59) && guard < 200);
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL midreset_reach: sweep never showed pht 59 within %0d cycles", guard);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if ({upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready, fifo_count}
        !== {1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL midreset_async: en=%b init=%b pht=%0d bht=%0d tk=%b busy=%b rdy=%b cnt=%0d, want reset values",
               upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready, fifo_count);
    end
    tick();
    reset = 0;
    fifo_m.delete();
    for (int k = 1; k <= NPHT + 1; k++) begin
      tick();
      obs = {upd_en, upd_init, upd_pht_index, upd_bht_index, upd_taken, busy, ret_ready};
      if (k <= NPHT) exp = {1'b1, 1'b1, 7'(k - 1), 4'((k - 1) % 16), 1'b0, 1'b1, 1'b0};
      else           exp = {1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL postreset_cycle_%0d: got %h, want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    run_traffic(150, 60, 0);
    run_traffic(60, 90, 1);
    run_traffic(6, 0, 0);
    checks++;
    if (fifo_count !== 3'd0 || fifo_m.size() != 0) begin
      errors++;
      $display("FAIL random_drain: dut %0d model %0d, want 0", fifo_count, fifo_m.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_init_req();
    test_random();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_update_sequencer.md
# bp_update_sequencer

Write-port controller for the branch predictor tables (4-bit BHT history registers and 128-entry 2-bit PHT). After reset it sweeps both tables to their initial values. In normal operation it accepts up to two resolved-branch updates per cycle from the two retire slots and buffers them in a FIFO. It then issues them one per cycle on the predictor's single update port, so the predictor never needs a multi-entry reset loop or a second write port.

## Interface
Parameters:
- DEPTH, 4: update FIFO entries (power of two, ≥2)
- PHT_AW, 7: PHT index width
- BHT_AW, 4: BHT index width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- init_req  in  1  single-cycle pulse; restart table sweep
- ret0_valid  in  1  retire slot 0 carries a resolved branch
- ret0_pht_index  in  PHT_AW  PHT index captured at fetch
- ret0_bht_index  in  BHT_AW  BHT index captured at fetch
- ret0_taken  in  1  actual branch outcome
- ret1_valid / ret1_pht_index / ret1_bht_index / ret1_taken  in  1/PHT_AW/BHT_AW/1  same for slot 1 (younger)
- ret_ready  out  1  both slots may present this cycle
- upd_en  out  1  write strobe to predictor
- upd_init  out  1  1 = write initial values (PHT←2'b11, BHT←0); 0 = normal FSM/shift update
- upd_pht_index  out  PHT_AW  PHT entry to write
- upd_bht_index  out  BHT_AW  BHT entry to write
- upd_taken  out  1  outcome for FSM and history shift
- busy  out  1  sweep in progress
- fifo_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- States: INIT, RUN. Reset enters INIT with sweep counter = 0.
- INIT:
  - Each cycle: upd_en=1, upd_init=1, upd_pht_index=cnt, upd_bht_index=cnt[BHT_AW-1:0], upd_taken=0.
  - cnt increments each cycle. Finishing the write at cnt = 2^PHT_AW−1 moves the block to RUN.
  - Duplicate BHT writes during the sweep are harmless.
  - ret_ready=0 and busy=1 throughout INIT.
- RUN:
  - ret_ready = (DEPTH − fifo_count ≥ 2).
  - On a cycle with ret_ready=1, each valid slot enqueues; slot 0 is written before slot 1.
  - A valid slot presented while ret_ready=0 is dropped. The retire stage must hold off, so a drop is a protocol violation and the checker flags it.
  - Each cycle, if the FIFO is non-empty, the head entry drives upd_* with upd_en=1 and upd_init=0, and the head is popped.
- init_req:
  - Accepted in any state, including mid-sweep.
  - The FIFO is cleared, cnt resets to 0 and the state becomes INIT on the next edge.
  - Pending updates are discarded.
- Simultaneous enqueue and dequeue: count_next = count + pushes − pop. An entry cannot be pushed and popped in the same cycle (no bypass).
- Pointers are DEPTH-wrapping, with fifo_count as the full/empty authority.

## Timing
- Reset values:
  - state=INIT, cnt=0, fifo empty.
  - upd_en=0, upd_init=0, upd_* indices=0, upd_taken=0.
  - busy=1, ret_ready=0, fifo_count=0.
- upd_* outputs are registered.
- First sweep write appears one cycle after reset deassert. The sweep lasts exactly 2^PHT_AW cycles. ret_ready first rises the cycle after the last sweep write.
- Update latency: a branch enqueued at edge N appears on upd_* in cycle N+1 if the FIFO was empty. A second entry from the same cycle appears in N+2.
- Throughput: 1 update/cycle sustained. Two pushes per cycle fill the FIFO; ret_ready drops when fewer than 2 entries are free.
- fifo_count and ret_ready are derived from registered state only; there is no combinational path from ret*_valid.

## Structure
- Shared package bp_pkg:
  - PHT/BHT widths
  - 2-bit counter encodings (STRONG_T=2'b11, WEAK_T=2'b10, WEAK_NT=2'b01, STRONG_NT=2'b00)
  - PHT_INIT=STRONG_T, BHT_INIT=0
  - bp_upd_t struct {pht_index, bht_index, taken}
  - state enum {INIT, RUN}
- One sub-module: bp_upd_fifo, a 2-write/1-read synchronous FIFO of bp_upd_t with count output. The sequencer FSM and sweep counter are in the top.

## Test plan
- Reset, release, run 130 cycles → upd_en=1, upd_init=1 for exactly 128 cycles; pht_index 0..127 in order; busy falls, ret_ready rises on cycle 129.
- After init, slot0 {pht 5, bht 3, taken 1} alone → next cycle upd_en=1, upd_init=0, pht 5, bht 3, taken 1; fifo_count returns to 0.
- Both slots valid {pht 10,T} and {pht 11,NT} in one cycle → upd stream pht 10 then 11 on consecutive cycles.
- Both slots valid every cycle for 6 cycles → fifo_count climbs to 3 (DEPTH 4), ret_ready falls; the bench withholds when ready=0 and no entry is lost; the drained order matches the push order.
- init_req while the FIFO holds 3 entries → no queued update emitted; sweep restarts at pht 0; fifo_count=0.
- Assert reset mid-sweep at cnt 60 → outputs return to reset values asynchronously; sweep restarts at 0 after release.
